fetch_seq: RTL and testbench

- Fetch sequencer for the MIPS core. Owns the PC register and drives the next-PC unit's operation select, base PC and immediate.
- Runs a request/acknowledge handshake to instruction memory and presents fetched words to decode with a valid/ready handshake.
- Applies branch/jump redirects from the execute stage, discarding wrong-path fetches.

---
 rtl/fetch_seq_pkg.sv | 29 ++
 rtl/fetch_seq_if.sv | 45 ++++
 rtl/fetch_seq.sv | 112 +++++++++++
 tb/tb_fetch_seq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared encodings for the fetch sequencer: next-PC operation selects,
// fetch FSM states and the bundle handed to the next-PC unit.
package fetch_seq_pkg;

  localparam int PC_W   = 30;
  localparam int IMM_W  = 26;
  localparam int OP_W   = 3;
  localparam int INST_W = 32;

  localparam logic [OP_W-1:0] NPC_PLUS4  = 3'b000;
  localparam logic [OP_W-1:0] NPC_BRANCH = 3'b001;
  localparam logic [OP_W-1:0] NPC_JUMP   = 3'b010;

  localparam logic [1:0] FS_IDLE  = 2'b00;
  localparam logic [1:0] FS_FETCH = 2'b01;
  localparam logic [1:0] FS_HOLD  = 2'b10;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [PC_W-1:0]  pc;
    logic [IMM_W-1:0] imm;
  } npc_req_t;

  // Only taken branches and jumps may steer the PC; anything else is noise.
  function automatic logic is_redirect_op(input logic [OP_W-1:0] op);
    return (op == NPC_BRANCH) || (op == NPC_JUMP);
  endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// Bundle of the instruction-memory, decode, redirect and next-PC signals
// around the fetch sequencer; master is the sequencer side.
interface fetch_seq_if;

  logic                                imem_req;
  logic [fetch_seq_pkg::PC_W-1:0]      imem_addr;
  logic                                imem_ack;
  logic [fetch_seq_pkg::INST_W-1:0]    imem_rdata;

  logic                                if_valid;
  logic                                if_ready;
  logic [fetch_seq_pkg::INST_W-1:0]    if_inst;
  logic [fetch_seq_pkg::PC_W-1:0]      if_pc;

  logic                                redirect_valid;
  logic [fetch_seq_pkg::OP_W-1:0]      redirect_op;
  logic [fetch_seq_pkg::PC_W-1:0]      redirect_pc;
  logic [fetch_seq_pkg::IMM_W-1:0]     redirect_imm;

  logic [fetch_seq_pkg::OP_W-1:0]      npc_op;
  logic [fetch_seq_pkg::PC_W-1:0]      npc_pc;
  logic [fetch_seq_pkg::IMM_W-1:0]     npc_imm;
  logic [fetch_seq_pkg::PC_W-1:0]      npc_in;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output if_valid, if_inst, if_pc,
    input  if_ready,
    input  redirect_valid, redirect_op, redirect_pc, redirect_imm,
    output npc_op, npc_pc, npc_imm,
    input  npc_in
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  if_valid, if_inst, if_pc,
    output if_ready,
    output redirect_valid, redirect_op, redirect_pc, redirect_imm,
    input  npc_op, npc_pc, npc_imm,
    output npc_in
  );

endinterface

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC, runs one imem request at a time, holds the
// fetched word for decode and squashes wrong-path fetches on redirects.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic         clk,
  input logic         rst_n,
  fetch_seq_if.master bus
);

  localparam logic [PC_W-1:0] RESET_WPC = RESET_PC[31:2];

  logic [1:0]        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              discard_q, discard_d;
  logic [PC_W-1:0]   imem_addr_q, imem_addr_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;
  logic [PC_W-1:0]   if_pc_q, if_pc_d;

  logic     redir_acc;
  logic     ack_live;
  npc_req_t npc_sel;

  assign redir_acc = bus.redirect_valid && is_redirect_op(bus.redirect_op);
  // Acks outside FETCH belong to a request that no longer exists.
  assign ack_live  = (state_q == FS_FETCH) && bus.imem_ack;

  always_comb begin
    npc_sel = '{op: NPC_PLUS4, pc: pc_q, imm: '0};
    if (redir_acc) begin
      npc_sel = '{op: bus.redirect_op, pc: bus.redirect_pc, imm: bus.redirect_imm};
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (redir_acc) begin
      pc_d = bus.npc_in;
    end else if (ack_live && !discard_q) begin
      pc_d = bus.npc_in;
    end
  end

  // Every time a new request is launched its address is the updated PC,
  // so a redirect in the launching cycle lands directly on the target.
  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    imem_addr_d = imem_addr_q;
    if_inst_d   = if_inst_q;
    if_pc_d     = if_pc_q;
    case (state_q)
      FS_IDLE: begin
        state_d     = FS_FETCH;
        imem_addr_d = pc_d;
      end
      FS_FETCH: begin
        if (bus.imem_ack) begin
          if (discard_q || redir_acc) begin
            discard_d   = 1'b0;
            imem_addr_d = pc_d;
          end else begin
            if_inst_d = bus.imem_rdata;
            if_pc_d   = imem_addr_q;
            state_d   = FS_HOLD;
          end
        end else if (redir_acc) begin
          discard_d = 1'b1;
        end
      end
      FS_HOLD: begin
        if (redir_acc || bus.if_ready) begin
          state_d     = FS_FETCH;
          imem_addr_d = pc_d;
        end
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FS_IDLE;
      pc_q        <= RESET_WPC;
      discard_q   <= 1'b0;
      imem_addr_q <= RESET_WPC;
      if_inst_q   <= '0;
      if_pc_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      imem_addr_q <= imem_addr_d;
      if_inst_q   <= if_inst_d;
      if_pc_q     <= if_pc_d;
    end
  end

  assign bus.imem_req  = (state_q == FS_FETCH);
  assign bus.imem_addr = imem_addr_q;
  assign bus.if_valid  = (state_q == FS_HOLD);
  assign bus.if_inst   = if_inst_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.npc_op    = npc_sel.op;
  assign bus.npc_pc    = npc_sel.pc;
  assign bus.npc_imm   = npc_sel.imm;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed plus randomized bench for fetch_seq with an imem responder,
// a next-PC unit model and an expected-fetch-stream reference.
module tb_fetch_seq;
  import fetch_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  logic [29:0] exp_pc;
  logic [29:0] a;
  logic [29:0] rp;
  logic [25:0] ri;
  logic [2:0]  rop;
  int          mode;
  int          adly;
  int          rdly;

  fetch_seq_if bus ();

  fetch_seq #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    return {wa[15:0], ~wa[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Word-address target of a taken branch or jump, from the ISA rules.
  function automatic logic [29:0] tgt(input logic [2:0] op, input logic [29:0] pc,
                                      input logic [25:0] imm);
    logic [29:0] p1;
    p1 = pc + 30'd1;
    if (op == NPC_BRANCH) return p1 + {{14{imm[15]}}, imm[15:0]};
    return {p1[29:26], imm};
  endfunction

  function automatic logic [29:0] npc_unit(input logic [2:0] op, input logic [29:0] pc,
                                           input logic [25:0] imm);
    if (op == NPC_PLUS4) return pc + 30'd1;
    return tgt(op, pc, imm);
  endfunction

  assign bus.npc_in = npc_unit(bus.npc_op, bus.npc_pc, bus.npc_imm);

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk(tag, 32'(bus.imem_req), 32'd1);
  endtask

  task automatic ack_after(input int dly, input logic [29:0] wa);
    for (int i = 0; i < dly; i++) begin
      chk("req_stable", 32'(bus.imem_req), 32'd1);
      chk("addr_stable", 32'(bus.imem_addr), 32'(wa));
      cyc();
    end
    chk("addr_at_ack", 32'(bus.imem_addr), 32'(wa));
    chk("valid_in_fetch", 32'(bus.if_valid), 32'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = mem_word(wa);
    cyc();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
  endtask

  task automatic check_held(input logic [29:0] wa);
    chk("held_valid", 32'(bus.if_valid), 32'd1);
    chk("held_pc", 32'(bus.if_pc), 32'(wa));
    chk("held_inst", bus.if_inst, mem_word(wa));
    chk("held_req", 32'(bus.imem_req), 32'd0);
  endtask

  task automatic hold_stall(input int n, input logic [29:0] wa);
    for (int i = 0; i < n; i++) begin
      bus.if_ready = 1'b0;
      cyc();
      check_held(wa);
    end
  endtask

  task automatic accept(input logic [29:0] wa);
    bus.if_ready = 1'b1;
    cyc();
    bus.if_ready = 1'b0;
    $display("txn accept if_pc=%h inst=%h", wa, mem_word(wa));
    chk("acc_valid", 32'(bus.if_valid), 32'd0);
    chk("acc_req", 32'(bus.imem_req), 32'd1);
    chk("acc_next_addr", 32'(bus.imem_addr), 32'(wa + 30'd1));
  endtask

  task automatic redirect(input logic [2:0] op, input logic [29:0] pc, input logic [25:0] imm,
                          input logic with_ack, input logic [29:0] wa);
    bus.redirect_valid = 1'b1;
    bus.redirect_op    = op;
    bus.redirect_pc    = pc;
    bus.redirect_imm   = imm;
    if (with_ack) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = mem_word(wa);
    end
    #1;
    chk("npc_op", 32'(bus.npc_op), 32'(op));
    chk("npc_pc", 32'(bus.npc_pc), 32'(pc));
    chk("npc_imm", 32'(bus.npc_imm), 32'(imm));
    cyc();
    $display("txn redirect op=%0d pc=%h imm=%h ack=%0d", op, pc, imm, with_ack);
    bus.redirect_valid = 1'b0;
    bus.imem_ack       = 1'b0;
    bus.imem_rdata     = '0;
  endtask

  task automatic check_squashed(input string tag, input logic [29:0] target);
    chk({tag, "_valid"}, 32'(bus.if_valid), 32'd0);
    chk({tag, "_req"}, 32'(bus.imem_req), 32'd1);
    chk({tag, "_addr"}, 32'(bus.imem_addr), 32'(target));
  endtask

  task automatic rand_redirect();
    rop = ($urandom_range(0, 1) == 0) ? NPC_BRANCH : NPC_JUMP;
    rp  = 30'hC00 + 30'($urandom_range(0, 255));
    ri  = (rop == NPC_BRANCH) ? 26'($urandom_range(0, 31)) - 26'd16
                              : 26'hC00 + 26'($urandom_range(0, 1023));
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.imem_ack       = 1'b0;
    bus.imem_rdata     = '0;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_op    = NPC_PLUS4;
    bus.redirect_pc    = '0;
    bus.redirect_imm   = '0;
    cyc();
    cyc();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_inst", bus.if_inst, 32'd0);
    chk("rst_ifpc", 32'(bus.if_pc), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'h0000_0C00);
    chk("rst_npc_op", 32'(bus.npc_op), 32'(NPC_PLUS4));
    chk("rst_npc_pc", 32'(bus.npc_pc), 32'h0000_0C00);
    rst_n  = 1'b1;
    exp_pc = 30'hC00;

    // Sequential fetches: 0xC00, 0xC01, 0xC02
    for (int k = 0; k < 3; k++) begin
      wait_req("seq_req");
      chk("seq_addr", 32'(bus.imem_addr), 32'(30'hC00 + 30'(k)));
      ack_after(1, exp_pc);
      check_held(exp_pc);
      accept(exp_pc);
      exp_pc = exp_pc + 30'd1;
    end

    // Branch while a word is held: word squashed, fetch goes to 0xC05
    wait_req("br_req");
    ack_after(0, exp_pc);
    check_held(exp_pc);
    hold_stall(1, exp_pc);
    redirect(NPC_BRANCH, 30'hC01, 26'h3, 1'b0, exp_pc);
    check_squashed("br", 30'hC05);
    exp_pc = 30'hC05;

    // Redirect while a request is outstanding: data dropped, then target 0xC00
    wait_req("out_req");
    redirect(NPC_BRANCH, 30'hC05, 26'h3FF_FFFA, 1'b0, exp_pc);
    ack_after(2, 30'hC05);
    check_squashed("out", 30'hC00);
    exp_pc = 30'hC00;
    ack_after(0, exp_pc);
    check_held(exp_pc);
    accept(exp_pc);
    exp_pc = exp_pc + 30'd1;

    // Jump in the same cycle as the ack: data dropped, next fetch 0xC10 delivered
    wait_req("jmp_req");
    redirect(NPC_JUMP, 30'hC02, 26'h0000C10, 1'b1, exp_pc);
    check_squashed("jmp", 30'hC10);
    exp_pc = 30'hC10;
    ack_after(0, exp_pc);
    check_held(exp_pc);

    // Backpressure for 5 cycles, then release
    hold_stall(5, exp_pc);
    accept(exp_pc);
    exp_pc = exp_pc + 30'd1;

    // Randomized traffic against the expected fetch stream
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 4);
      adly = $urandom_range(0, 3);
      rdly = $urandom_range(0, 3);
      wait_req("rnd_req");
      chk("rnd_addr", 32'(bus.imem_addr), 32'(exp_pc));
      a = exp_pc;
      case (mode)
        1: begin
          rand_redirect();
          redirect(rop, rp, ri, 1'b0, a);
          exp_pc = tgt(rop, rp, ri);
          if ($urandom_range(0, 1) == 1) begin
            rand_redirect();
            redirect(rop, rp, ri, 1'b0, a);
            exp_pc = tgt(rop, rp, ri);
          end
          ack_after(adly, a);
          check_squashed("rnd_pend", exp_pc);
        end
        2: begin
          for (int i = 0; i < adly; i++) begin
            chk("rnd_ackr_addr", 32'(bus.imem_addr), 32'(a));
            cyc();
          end
          rand_redirect();
          redirect(rop, rp, ri, 1'b1, a);
          exp_pc = tgt(rop, rp, ri);
          check_squashed("rnd_ackr", exp_pc);
        end
        3: begin
          ack_after(adly, a);
          check_held(a);
          hold_stall(rdly, a);
          bus.if_ready = ($urandom_range(0, 1) == 1);
          rand_redirect();
          redirect(rop, rp, ri, 1'b0, a);
          bus.if_ready = 1'b0;
          exp_pc = tgt(rop, rp, ri);
          check_squashed("rnd_hold", exp_pc);
        end
        default: begin
          if (mode == 4) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_op    = 3'($urandom_range(3, 7));
            bus.redirect_pc    = 30'h1234;
            bus.redirect_imm   = 26'h55;
            #1;
            chk("bad_op_npc_op", 32'(bus.npc_op), 32'(NPC_PLUS4));
            chk("bad_op_npc_pc", 32'(bus.npc_pc), 32'(a));
            chk("bad_op_npc_imm", 32'(bus.npc_imm), 32'd0);
            cyc();
            bus.redirect_valid = 1'b0;
            $display("txn ignored redirect op=%0d", bus.redirect_op);
          end
          ack_after(adly, a);
          check_held(a);
          hold_stall(rdly, a);
          accept(a);
          exp_pc = a + 30'd1;
        end
      endcase
    end

    // Asynchronous reset mid-FETCH, with a stale ack around the release
    wait_req("ar_req");
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req_drop", 32'(bus.imem_req), 32'd0);
    chk("ar_valid_drop", 32'(bus.if_valid), 32'd0);
    chk("ar_addr", 32'(bus.imem_addr), 32'h0000_0C00);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    chk("ar_first_req", 32'(bus.imem_req), 32'd1);
    chk("ar_first_addr", 32'(bus.imem_addr), 32'h0000_0C00);
    chk("ar_no_valid", 32'(bus.if_valid), 32'd0);
    ack_after(1, 30'hC00);
    check_held(30'hC00);
    accept(30'hC00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
